// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one syncFIFO write port
// between NUM_REQ producers, with bounded bursts per grant.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                          w_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [GW-1:0]                 grant_id,
    output logic                          grant_active,
    output logic [CNT_WIDTH-1:0]          wr_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_id_q, grant_id_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_id;
    logic                 release_grant;

    // Round-robin search starting just after the last grant.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = GW'(idx);
            end
        end
    end

    // Port-facing outputs, gated by reset and the live full flag.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = reset && (state_q == GRANT)
                           && (int'(grant_id_q) == i)
                           && !fifo_full;
        end
        fifo_w_en    = req_valid[grant_id_q] & req_ready[grant_id_q];
        fifo_din     = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
        grant_id     = grant_id_q;
        grant_active = (state_q == GRANT);
        wr_count     = wr_count_q;
    end

    // Next-state: burst accounting, release and re-arbitration.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        burst_cnt_d   = burst_cnt_q;
        wr_count_d    = wr_count_q;
        release_grant = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d      = GRANT;
                    grant_id_d   = pick_id;
                    last_grant_d = pick_id;
                    burst_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (fifo_w_en) begin
                    if (wr_count_q != '1) begin
                        wr_count_d = wr_count_q + CNT_WIDTH'(1);
                    end
                    if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
                        release_grant = 1'b1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                end else if (!fifo_full && !req_valid[grant_id_q]) begin
                    release_grant = 1'b1;
                end

                if (release_grant) begin
                    if (pick_found) begin
                        grant_id_d   = pick_id;
                        last_grant_d = pick_id;
                        burst_cnt_d  = '0;
                    end else begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset hands first priority to requester 0.
    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            wr_count_q   <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: fairness, bursts,
// full back-pressure, early release and mid-burst reset.
module tb_fifo_write_arbiter;

    logic        w_clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [3:0]  fifo_din;
    logic [1:0]  grant_id;
    logic        grant_active;
    logic [15:0] wr_count;

    int checks;
    int failures;

    fifo_write_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(4),
        .MAX_BURST(4),
        .CNT_WIDTH(16)
    ) dut (
        .w_clk(w_clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_w_en(fifo_w_en),
        .fifo_din(fifo_din),
        .grant_id(grant_id),
        .grant_active(grant_active),
        .wr_count(wr_count)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] owner;
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 16'h0000;
        fifo_full = 1'b0;
        #12;
        chk("rst_active", 32'(grant_active), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_cnt", 32'(wr_count), 32'd0);
        chk("rst_wen", 32'(fifo_w_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        tick();

        // All four requesters valid: 4 writes each in order 0..3.
        req_valid = 4'b1111;
        req_data  = 16'hDCBA;
        #1;
        chk("idle_no_write", 32'(fifo_w_en), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            owner = 4'(i / 4);
            chk("rr_gid", 32'(grant_id), 32'(owner));
            chk("rr_wen", 32'(fifo_w_en), 32'd1);
            chk("rr_din", 32'(fifo_din), 32'(4'hA + owner));
            tick();
        end
        chk("rr_cnt16", 32'(wr_count), 32'd16);
        chk("rr_wrap_gid", 32'(grant_id), 32'd0);
        req_valid = 4'b0000;
        tick();
        chk("to_idle", 32'(grant_active), 32'd0);

        // Sole requester 2: no bubble across burst boundaries.
        req_valid = 4'b0100;
        req_data  = 16'h0500;
        #1;
        chk("r2_idle_wen", 32'(fifo_w_en), 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("r2_gid", 32'(grant_id), 32'd2);
            chk("r2_wen", 32'(fifo_w_en), 32'd1);
            chk("r2_din", 32'(fifo_din), 32'h5);
            tick();
        end
        chk("r2_cnt", 32'(wr_count), 32'd26);
        req_valid = 4'b0000;
        tick();
        chk("r2_idle", 32'(grant_active), 32'd0);

        // Requester 1: 2 writes, 5 cycles full, then 2 more writes.
        req_valid = 4'b0010;
        req_data  = 16'h0070;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("f_pre_wen", 32'(fifo_w_en), 32'd1);
            chk("f_pre_gid", 32'(grant_id), 32'd1);
            tick();
        end
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = (k == 2) ? 4'b0000 : 4'b0010;
            #1;
            chk("f_wen", 32'(fifo_w_en), 32'd0);
            chk("f_ready", 32'(req_ready), 32'd0);
            chk("f_gid", 32'(grant_id), 32'd1);
            chk("f_active", 32'(grant_active), 32'd1);
            tick();
        end
        fifo_full = 1'b0;
        req_valid = 4'b0011;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("f_post_wen", 32'(fifo_w_en), 32'd1);
            chk("f_post_ready", 32'(req_ready), 32'b0010);
            tick();
        end
        chk("f_release_gid", 32'(grant_id), 32'd0);
        chk("f_cnt", 32'(wr_count), 32'd30);

        // Requester 3 drops after one write; requester 0 takes over.
        req_valid = 4'b1000;
        req_data  = 16'h9000;
        #1;
        chk("d_switch_wen", 32'(fifo_w_en), 32'd0);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("d_r3_gid", 32'(grant_id), 32'd3);
        chk("d_r3_din", 32'(fifo_din), 32'h9);
        chk("d_r3_wen", 32'(fifo_w_en), 32'd1);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("d_drop_wen", 32'(fifo_w_en), 32'd0);
        tick();
        chk("d_r0_gid", 32'(grant_id), 32'd0);
        chk("d_r0_active", 32'(grant_active), 32'd1);
        chk("d_r0_burst", 32'(dut.burst_cnt_q), 32'd0);
        chk("d_cnt", 32'(wr_count), 32'd31);

        // Reset during the third write of requester 1's burst.
        req_valid = 4'b0010;
        req_data  = 16'h00E0;
        tick();
        tick();
        tick();
        chk("r_pre_wen", 32'(fifo_w_en), 32'd1);
        chk("r_pre_cnt", 32'(wr_count), 32'd33);
        #2;
        reset = 1'b0;
        #1;
        chk("r_wen", 32'(fifo_w_en), 32'd0);
        chk("r_ready", 32'(req_ready), 32'd0);
        chk("r_active", 32'(grant_active), 32'd0);
        chk("r_cnt", 32'(wr_count), 32'd0);
        chk("r_gid", 32'(grant_id), 32'd0);
        req_valid = 4'b0011;
        reset     = 1'b1;
        tick();
        chk("r_first_gid", 32'(grant_id), 32'd0);
        chk("r_first_wen", 32'(fifo_w_en), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of syncFIFO between NUM_REQ independent producers.
- Sits on the FIFO write-clock domain, upstream of syncFIFO's w_en/din/full.
- Grants one requester at a time for a bounded burst and never issues a write while the FIFO reports full.
- Keeps a saturating count of accepted writes for debug.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 4, FIFO data width; matches syncFIFO din.
- MAX_BURST, 4, maximum consecutive writes per grant (1..16).
- CNT_WIDTH, 16, width of the accepted-write counter.

Ports:
- w_clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  per-requester data-valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both 1 at the clock edge.
- fifo_full  in  1  full flag from syncFIFO.
- fifo_w_en  out  1  write enable to syncFIFO.
- fifo_din  out  DATA_WIDTH  write data to syncFIFO.
- grant_id  out  clog2(NUM_REQ)  currently granted requester.
- grant_active  out  1  1 while in GRANT state.
- wr_count  out  CNT_WIDTH  saturating count of accepted writes.

Behaviour:
- Registered state: state (IDLE/GRANT), grant_id, last_grant, burst_cnt, wr_count.
- Reset (reset==0, async):
  - state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (requester 0 has first priority), burst_cnt=0, wr_count=0.
  - Combinationally forces req_ready=0 and fifo_w_en=0.
- Outputs are combinational from state:
  - req_ready[i] = (state==GRANT) & (i==grant_id) & !fifo_full.
  - fifo_w_en = req_valid[grant_id] & req_ready[grant_id].
  - fifo_din = req_data slice of grant_id. Value is don't-care when fifo_w_en=0, but is always driven from the grant_id slice.
  - Zero-cycle latency: data presented at the edge where fifo_w_en=1 is written to the FIFO at that edge.
- Round-robin pick:
  - Search starts at (last_grant+1) mod NUM_REQ and wraps.
  - The first requester with req_valid=1 wins.
- IDLE:
  - No valid: stay IDLE.
  - Any valid: state=GRANT, grant_id=winner, last_grant=winner, burst_cnt=0.
  - No write occurs in the IDLE cycle.
- GRANT, write accepted (fifo_w_en=1):
  - wr_count increments, saturating at all-ones.
  - If burst_cnt==MAX_BURST-1, release.
  - Otherwise burst_cnt increments.
- GRANT, fifo_full=1:
  - Hold grant; burst_cnt frozen; no release, even if req_valid drops.
  - A full FIFO never causes a grant switch.
- GRANT, fifo_full=0 and req_valid[grant_id]=0:
  - Release (requester idle).
- Release:
  - Re-run the round-robin pick in the same cycle, excluding nothing, starting after last_grant.
  - If a winner exists: stay GRANT with the new grant_id/last_grant and burst_cnt=0 (no bubble).
  - If no winner: go to IDLE.
  - A sole active requester therefore regains the grant immediately after its burst.
- Fairness: with all requesters continuously valid and FIFO not full, the grant order is 0,1,2,...,NUM_REQ-1,0,... with exactly MAX_BURST writes each.
- Overflow safety: fifo_w_en is never 1 while fifo_full=1.
- Simultaneous write and full rise: the FIFO's own flag timing governs; the arbiter only gates on the current fifo_full.
- Reset mid-burst: grant lost immediately, no partial write; after release, arbitration restarts at requester 0.
- req_valid of non-granted requesters has no effect on outputs.

Test Plan:
- Reset then all 4 requesters valid, FIFO never full:
  - Write grant sequence 0,0,0,0,1,1,1,1,2,...,3,0.
  - fifo_din equals the owner's data on each write.
  - wr_count=16 after 16 edges of GRANT.
- Only requester 2 valid, data 0x5 continuous:
  - Enters GRANT one cycle after valid, then writes every cycle with no bubble across burst boundaries.
  - grant_id stays 2.
- Requester 1 granted, fifo_full=1 for 5 cycles mid-burst after 2 writes:
  - fifo_w_en=0 and req_ready=0 for 5 cycles; grant_id stays 1.
  - After full drops, exactly 2 more writes, then release.
- Requester 3 drops valid after 1 write while requester 0 is valid:
  - Next edge grant_id=0, burst_cnt=0, no idle cycle.
- Assert reset during the 3rd write of requester 1's burst:
  - Outputs go to 0 asynchronously and wr_count=0.
  - After release with requesters 1 and 0 valid, first grant goes to 0.
- Connect to syncFIFO with random valids and reads disabled:
  - fifo_w_en never 1 with full=1.
  - Data read back after enabling reads matches the accepted order.
